// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

  localparam int SERIAL_SUB_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor_bit.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor_bit (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor (operand0 - operand1), LSB first, one bit per cycle behind valid/ready ports.
// Defining SERIAL_SUB_OVERFLOW_EN adds a registered signed-overflow output.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = SERIAL_SUB_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand0,
  input  logic [WIDTH-1:0] operand1,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             overflow,
`endif
  output logic [WIDTH-1:0] result,
  output logic             borrow
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] r_sh;
  logic [CNT_W-1:0] cnt;
  logic             borrow_r;
  logic             in_ready_r;
  logic             out_valid_r;
  logic             d;
  logic             bout;

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic a_msb;
  logic b_msb;
  logic overflow_r;
  assign overflow = overflow_r;
`endif

  full_subtractor_bit u_cell (
    .a   (a_sh[0]),
    .b   (b_sh[0]),
    .bin (borrow_r),
    .d   (d),
    .bout(bout)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      r_sh        <= '0;
      borrow_r    <= 1'b0;
      cnt         <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      overflow_r  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh       <= operand0;
            b_sh       <= operand1;
            borrow_r   <= 1'b0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            state      <= BUSY;
`ifdef SERIAL_SUB_OVERFLOW_EN
            a_msb      <= operand0[WIDTH-1];
            b_msb      <= operand1[WIDTH-1];
`endif
          end
        end
        BUSY: begin
          // Difference bits enter at the top so bit 0 lands in r_sh[0] after WIDTH shifts.
          r_sh     <= {d, r_sh[WIDTH-1:1]};
          a_sh     <= a_sh >> 1;
          b_sh     <= b_sh >> 1;
          borrow_r <= bout;
          if (cnt == LAST_BIT) begin
            cnt         <= '0;
            out_valid_r <= 1'b1;
            state       <= DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
            overflow_r  <= (a_msb != b_msb) & (d != a_msb);
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            in_ready_r  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          out_valid_r <= 1'b0;
          in_ready_r  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign result    = r_sh;
  assign borrow    = borrow_r;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and sampled-sweep bench for serial_subtractor with a queue-based scoreboard.
// Overflow checks are compiled in only when SERIAL_SUB_OVERFLOW_EN is defined.
module tb_serial_subtractor;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         brw;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] operand0 = '0;
  logic [W-1:0] operand1 = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         borrow;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic         overflow;
`endif

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .operand0 (operand0),
    .operand1 (operand1),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .overflow (overflow),
`endif
    .result   (result),
    .borrow   (borrow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running, observed hang, required completion");
    $fatal(1, "watchdog");
  end

  function automatic exp_t golden(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.a   = a;
    e.b   = b;
    e.res = a + ~b + W'(1);
    e.brw = (a < b);
    e.ovf = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
    return e;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits for in_ready, presents operands for exactly the accepting edge, then scrambles them.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input bit push);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check("send_ready", in_ready, 1);
    operand0 = a;
    operand1 = b;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (push) sb.push_back(golden(a, b));
    operand0 = W'($urandom);
    operand1 = W'($urandom);
  endtask

  task automatic wait_result(input string tag);
    int   n = 0;
    exp_t e;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    check({tag, "_valid"}, out_valid, 1);
    if (out_valid) begin
      check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check({tag, "_result"}, result, e.res);
        check({tag, "_borrow"}, borrow, e.brw);
`ifdef SERIAL_SUB_OVERFLOW_EN
        check({tag, "_overflow"}, overflow, e.ovf);
`endif
      end
      if (out_ready) tick();
    end
  endtask

  initial begin
    logic [W-1:0] corners [6];
    bit           stop;
    bit           seen;
    int           f0, acc, got, last;
    corners = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFE, 8'hFF};

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_borrow", borrow, 0);
    rst = 1'b1;
    tick();

    // Basic with exact latency
    send(8'h05, 8'h03, 1);
    repeat (W - 1) tick();
    check("lat_early", out_valid, 0);
    tick();
    check("lat_ontime", out_valid, 1);
    wait_result("basic");
    check("basic_drained", out_valid, 0);

    send(8'h00, 8'h01, 1);
    wait_result("wrap");
`ifdef SERIAL_SUB_OVERFLOW_EN
    send(8'h80, 8'h01, 1);
    wait_result("ovf_neg");
    send(8'h7F, 8'hFF, 1);
    wait_result("ovf_pos");
`endif

    // Backpressure with an ignored request pulse
    out_ready = 1'b0;
    send(8'hA0, 8'h0A, 1);
    for (int n = 0; n < 40 && !out_valid; n++) tick();
    for (int i = 0; i < 20; i++) begin
      check("bp_valid", out_valid, 1);
      check("bp_result", result, 8'h96);
      check("bp_in_ready", in_ready, 0);
      in_valid = (i == 5);
      operand0 = 8'h11;
      operand1 = 8'h22;
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_result("bp");
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      seen |= out_valid;
      tick();
    end
    check("bp_no_extra", seen, 0);
    check("bp_idle_ready", in_ready, 1);

    // Reset mid-operation discards the transaction
    send(8'hFF, 8'h01, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_result", result, 0);
    check("mid_rst_borrow", borrow, 0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("mid_rst_overflow", overflow, 0);
`endif
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      seen |= out_valid;
      tick();
    end
    check("mid_rst_no_output", seen, 0);
    send(8'h10, 8'h20, 1);
    wait_result("after_rst");

    // Reset wins over a simultaneous request
    operand0 = 8'h33;
    operand1 = 8'h11;
    in_valid = 1'b1;
    rst = 1'b0;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    check("rst_vs_valid_ready", in_ready, 1);
    seen = 1'b0;
    for (int i = 0; i < W + 2; i++) begin
      seen |= out_valid;
      tick();
    end
    check("rst_vs_valid_no_output", seen, 0);

    // Back-to-back with in_valid held high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    operand0  = W'($urandom);
    operand1  = W'($urandom);
    acc = 0;
    got = 0;
    last = 0;
    for (int c = 0; c < 200 && got < 6; c++) begin
      if (in_ready && acc < 6) begin
        sb.push_back(golden(operand0, operand1));
        if (acc > 0) check("b2b_interval", cyc - last, W + 2);
        last = cyc;
        acc++;
        tick();
        operand0 = W'($urandom);
        operand1 = W'($urandom);
        if (acc == 6) in_valid = 1'b0;
      end else if (out_valid) begin
        wait_result("b2b");
        got++;
      end else begin
        tick();
      end
    end
    in_valid = 1'b0;
    check("b2b_count", got, 6);
    check("b2b_sb_empty", sb.size(), 0);

    // Corner pairs, then random pairs; stop at the first disagreement
    f0 = fails;
    stop = 1'b0;
    for (int i = 0; i < 6 && !stop; i++) begin
      for (int j = 0; j < 6 && !stop; j++) begin
        send(corners[i], corners[j], 1);
        wait_result("corner");
        if (fails != f0) begin
          $display("sweep stopped at operand0=%h operand1=%h", corners[i], corners[j]);
          stop = 1'b1;
        end
      end
    end
    for (int k = 0; k < 1500 && !stop; k++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      send(ra, rb, 1);
      wait_result("sweep");
      if (fails != f0) begin
        $display("sweep stopped at operand0=%h operand1=%h", ra, rb);
        stop = 1'b1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
